// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between the pipeline and the multiply/divide unit
interface md_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, x, y, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, x, y, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative HI/LO multiply/divide unit (32-cycle shift-add / restoring divide)
// MDU_FAST_MUL_EN: single-cycle MULT/MULTU written at the start edge; division stays iterative.
module md_unit (
  input  logic      clk,
  input  logic      rst,
  md_unit_if.slave  bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg;
  logic        r_neg_rem;
  logic        r_dz;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_m;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic [31:0] w_xmag;
  logic [31:0] w_ymag;
  logic [32:0] w_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_mul_res;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_rem_res;
  logic [31:0] w_quo_res;

  // Both datapaths work on magnitudes; signs are reapplied on the final edge.
  assign w_signed = ~bus.op[0];
  assign w_xmag   = (w_signed && bus.x[31]) ? -bus.x : bus.x;
  assign w_ymag   = (w_signed && bus.y[31]) ? -bus.y : bus.y;

  // r_a = running high half, r_b = multiplier bits still to consume, r_m = multiplicand
  assign w_sum      = {1'b0, r_a} + (r_b[0] ? {1'b0, r_m} : 33'd0);
  assign w_mul_next = {w_sum, r_b[31:1]};
  assign w_mul_res  = r_neg ? -w_mul_next : w_mul_next;

  // r_a = partial remainder, r_b = dividend shifting out / quotient shifting in, r_m = divisor
  assign w_shift    = {r_a, r_b[31]};
  assign w_trial    = w_shift - {1'b0, r_m};
  assign w_qbit     = ~w_trial[32];
  assign w_rem_next = w_qbit ? w_trial[31:0] : w_shift[31:0];
  assign w_quo_next = {r_b[30:0], w_qbit};
  // A zero divisor yields an all-ones quotient magnitude that must not be negated.
  assign w_quo_res  = (r_neg && !r_dz) ? -w_quo_next : w_quo_next;
  assign w_rem_res  = r_neg_rem ? -w_rem_next : w_rem_next;

`ifdef MDU_FAST_MUL_EN
  logic [63:0] w_ext_x;
  logic [63:0] w_ext_y;
  logic [63:0] w_fast_prod;

  assign w_ext_x     = {{32{w_signed & bus.x[31]}}, bus.x};
  assign w_ext_y     = {{32{w_signed & bus.y[31]}}, bus.y};
  assign w_fast_prod = w_ext_x * w_ext_y;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_m       <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
`ifdef MDU_FAST_MUL_EN
            if (!bus.op[1]) begin
              {r_hi, r_lo} <= w_fast_prod;
              r_done       <= 1'b1;
            end else
`endif
            begin
              r_state   <= S_RUN;
              r_busy    <= 1'b1;
              r_cnt     <= 5'd0;
              r_is_div  <= bus.op[1];
              r_neg     <= w_signed & (bus.x[31] ^ bus.y[31]);
              r_neg_rem <= w_signed & bus.x[31];
              r_dz      <= (bus.y == 32'd0);
              r_a       <= 32'd0;
              r_b       <= w_xmag;
              r_m       <= w_ymag;
            end
          end else begin
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_is_div) begin
            r_a <= w_rem_next;
            r_b <= w_quo_next;
          end else begin
            {r_a, r_b} <= w_mul_next;
          end
          if (r_cnt == 5'd31) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem_res;
              r_lo <= w_quo_res;
            end else begin
              {r_hi, r_lo} <= w_mul_res;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed and randomized checks of md_unit against an arithmetic reference
module tb_md_unit;
  logic clk = 1'b0;
  logic rst;
  md_unit_if bus ();

  md_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} as the architecture defines it.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; return p; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  // hz >= 0 pulses start+mthi at that RUN cycle; with_mthi raises mthi alongside start.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hz, input bit with_mthi);
    logic [63:0] exp;
    logic [31:0] h0, l0;
    int n, exp_lat;
    bit held, busy_ok;
    exp     = model(op, a, b);
    n       = 0;
    held    = 1'b1;
    busy_ok = 1'b1;
    exp_lat = 32;
`ifdef MDU_FAST_MUL_EN
    if (!op[1]) exp_lat = 0;
`endif
    @(posedge clk); #1;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.x = a; bus.y = b;
    bus.mthi = with_mthi; bus.wdata = 32'h5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mthi = 1'b0;
    bus.x = $urandom; bus.y = $urandom; bus.op = 2'($urandom);
    while (!bus.done && n < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
      if (n == hz) begin bus.start = 1'b1; bus.mthi = 1'b1; bus.op = 2'd0; end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mthi = 1'b0;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy"}, {62'd0, bus.busy, busy_ok}, 64'd1);
    check({tag, "_held"}, {63'd0, held}, 64'd1);
    check({tag, "_result"}, {bus.hi, bus.lo}, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    bit done_seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.x = 32'd0; bus.y = 32'd0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
    @(posedge clk); #1;
    check("reset_state", {bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, -1, 1'b0);
    run_op("div_m7_2", 2'd2, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    run_op("mult_m3_5", 2'd0, 32'hFFFFFFFD, 32'd5, -1, 1'b0);
    run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    run_op("divu_dz", 2'd3, 32'd9, 32'd0, -1, 1'b0);
    run_op("div_dz", 2'd2, 32'hFFFFFFFC, 32'd0, -1, 1'b0);

    run_op("hz_run", 2'd3, 32'd100, 32'd7, 9, 1'b0);
    @(posedge clk); #1;
    bus.mtlo = 1'b1; bus.wdata = 32'hA5;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    check("mtlo_idle", {bus.hi, bus.lo}, {32'd2, 32'hA5});
    run_op("start_mthi", 2'd3, 32'd100, 32'd7, -1, 1'b1);

    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthi_mtlo_both", {bus.hi, bus.lo}, {32'h1234, 32'h1234});
    bus.start = 1'b1; bus.op = 2'd3; bus.x = 32'd100; bus.y = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_run", {bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      done_seen |= bus.done;
    end
    rst = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      done_seen |= bus.done;
    end
    check("rst_no_done", {63'd0, done_seen}, 64'd0);
    run_op("post_rst_divu", 2'd3, 32'd100, 32'd7, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("random", 2'($urandom), pick(), pick(), -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports listed below in order.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin the operation selected by op.
REQ-005 op  input  2  operation: 0 MULT (signed), 1 MULTU, 2 DIV (signed), 3 DIVU.
REQ-006 x  input  32  operand rs, the same operand bus that drives the ALU x input.
REQ-007 y  input  32  operand rt, the same operand bus that drives the ALU y input.
REQ-008 mthi  input  1  write wdata into HI.
REQ-009 mtlo  input  1  write wdata into LO.
REQ-010 wdata  input  32  data for mthi and mtlo.
REQ-011 busy  output  1  operation in progress; the pipeline stalls mfhi, mflo, mult and div while busy is high.
REQ-012 done  output  1  one-cycle pulse; HI and LO hold the new result.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 The state machine SHALL have two states, IDLE and RUN, plus a 5-bit iteration counter.
REQ-016 A start sampled in IDLE SHALL:
- capture x, y and op;
- enter RUN;
- clear the counter;
- raise busy from the next cycle.
REQ-017 A start sampled in RUN SHALL be ignored.
REQ-018 Division SHALL use a restoring shift-subtract algorithm on magnitudes, one quotient bit per cycle, taking exactly 32 RUN cycles.
REQ-019 Multiplication SHALL use shift-add on magnitudes, one bit per cycle, taking exactly 32 RUN cycles (see REQ-034 for the MDU_FAST_MUL_EN alternative).
REQ-020 On the clock edge that ends the 32nd RUN cycle, the block SHALL:
- write HI and LO;
- return to IDLE;
- drive done=1 for exactly the following cycle, with busy=0 in that same cycle.
REQ-021 MULT/MULTU results SHALL be {hi,lo} = the 64-bit product, signed or unsigned per op.
REQ-022 DIV/DIVU results SHALL be lo = quotient and hi = remainder.
REQ-023 Signed DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero (y==0, either mode) SHALL complete in 32 cycles with lo=32'hFFFFFFFF and hi=x.
REQ-025 Signed overflow (x=32'h80000000, y=32'hFFFFFFFF) SHALL give lo=32'h80000000 and hi=0.
REQ-026 mthi/mtlo in IDLE SHALL write HI/LO at the next edge; mthi and mtlo together SHALL write both registers.
REQ-027 mthi/mtlo while busy SHALL be ignored.
REQ-028 If start and mthi/mtlo are sampled in the same IDLE cycle, start SHALL take effect and mthi/mtlo SHALL be ignored.
REQ-029 HI and LO SHALL hold their old values throughout RUN, and any intermediate values SHALL stay in internal registers only.
REQ-030 Operand changes on x and y after start is sampled SHALL NOT affect the result.

Reset
REQ-031 Asserting rst SHALL immediately force:
- state IDLE and counter 0;
- busy=0, done=0, hi=0, lo=0;
- all internal working registers cleared.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no HI/LO update and no done pulse.
REQ-033 The first start sampled after rst deasserts SHALL be accepted normally.

Configuration
REQ-034 Macro MDU_FAST_MUL_EN:
- When defined, MULT/MULTU SHALL compute the product in the cycle start is sampled, write HI/LO at that edge, keep busy=0 throughout, and pulse done the following cycle.
- When undefined, multiplication SHALL use the 32-cycle iterative path of REQ-019.
- Division timing SHALL be identical in both builds.

Verification
REQ-035 DIVU with x=100, y=7: busy high for 32 cycles, then done pulse with lo=14 and hi=2.
REQ-036 DIV with x=-7 (32'hFFFFFFF9), y=2: lo=32'hFFFFFFFD (-3) and hi=32'hFFFFFFFF (-1); DIV with x=32'h80000000, y=-1: lo=32'h80000000, hi=0.
REQ-037 MULT with x=-3, y=5: hi=32'hFFFFFFFF and lo=32'hFFFFFFF1; MULTU with x=y=32'hFFFFFFFF: hi=32'hFFFFFFFE and lo=1; the bench SHALL check latency in both MDU_FAST_MUL_EN builds.
REQ-038 DIVU with y=0, x=9: lo=32'hFFFFFFFF and hi=9 after 32 cycles; DIV with y=0, x=-4: lo=32'hFFFFFFFF and hi=32'hFFFFFFFC.
REQ-039 Hazards, starting from DIVU 100/7:
- start and mthi (wdata=5) pulsed at cycle 10 -> both ignored, result unchanged;
- mtlo (wdata=32'hA5) in IDLE -> lo=32'hA5 next cycle;
- start together with mthi in IDLE -> division runs and HI is not set to wdata.
REQ-040 Assert rst at RUN cycle 15 with hi=lo=32'h1234 preloaded -> busy=0, hi=lo=0 immediately, no done pulse; a new DIVU 100/7 then completes correctly.
